rca_share_arbiter: RTL and testbench
====================================

// Module: rca_share_arbiter
// PURPOSE
//  Shares one 32-bit ripple-carry adder (thirtytwobitRCA, one combinational instance) between two requesters.
//  Each requester sends a packet of one or more 32-bit add beats over a valid/ready handshake.
//  Multi-beat packets form a multi-word add: the carry of each beat feeds the next beat of the same packet.
//  One registered result stage drives a single valid/ready response port toward the consumer.
// PARAMETERS
//  RR_EN   1   1 = round-robin between packets; 0 = fixed priority, req0 always wins
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  req0_valid   in   1   requester 0 beat valid
//  req0_ready   out  1   requester 0 beat accepted when valid&ready
//  req0_a       in   32  operand A
//  req0_b       in   32  operand B
//  req0_cin     in   1   carry-in; used on first beat of packet only
//  req0_last    in   1   final beat of packet
//  req1_*       -    -   identical set for requester 1
//  resp_valid   out  1   result held valid
//  resp_ready   in   1   consumer takes result when valid&ready
//  resp_sum     out  32  sum of accepted beat
//  resp_cout    out  1   carry-out of accepted beat
//  resp_id      out  1   requester that issued the beat
//  resp_last    out  1   copy of beat's last flag
//  resp_idx     out  4   beat index within packet, 0-based, saturates at 15
// BEHAVIOUR
//  Reset (async on rst_n low, held while low):
//   - State IDLE, carry reg 0, rr pointer = req0.
//   - resp_valid, resp_sum, resp_cout, resp_id, resp_last, resp_idx all 0.
//  out_free = !resp_valid | resp_ready.
//   - A beat is accepted only when out_free.
//   - The result register loads on accept; otherwise it holds while resp_valid & !resp_ready.
//   - Latency: accept at edge N -> resp_valid high after edge N.
//   - Throughput is one beat per cycle when resp_ready is held high.
//  FSM states:
//   IDLE:
//    - Winner is chosen combinationally this cycle.
//    - Both valid: the rr pointer side wins. RR_EN=0: req0 wins.
//    - winner_ready = out_free; loser_ready = 0.
//    - Accepted beat with last=0 -> LOCK(owner=winner), carry reg <- cout, idx <- 1.
//    - Accepted beat with last=1 -> stay IDLE, pointer <- other requester (if RR_EN).
//   LOCK:
//    - owner_ready = out_free; other side's ready = 0, even if the owner's valid is low (owner may stall).
//    - Adder cin = carry reg; the request cin is ignored.
//    - Each accept: carry reg <- cout, idx increments (saturating at 15).
//    - Accept with last=1 -> IDLE, pointer <- other requester (if RR_EN), carry reg <- 0, idx <- 0.
//  Adder: sum = a + b + cin, modulo 2^32; cout is bit 32.
//  Readies depend on valid only via the IDLE arbitration; valid must never depend on ready.
//  Requester must hold a, b, cin, last stable while valid & !ready.
//  Reset mid-packet: lock and any pending response are dropped; the requester restarts its packet.
// TESTING
//  1. req0 single beat a=0xFFFFFFFF b=1 cin=0 last=1 -> resp next cycle: sum=0, cout=1, id=0, idx=0.
//  2. req0 64-bit packet: beat0 a=0xFFFFFFFF b=1 cin=0; beat1 a=0 b=0 (last)
//     -> resp beat1: sum=1, cout=0, idx=1, last=1.
//  3. Both valid in IDLE, RR_EN=1, 1-beat packets, resp_ready=1
//     -> order id 0,1,0,1 on consecutive cycles; RR_EN=0 -> id stays 0 while req0 valid.
//  4. req0 locked, req0_valid drops for 3 cycles while req1 valid
//     -> req1_ready stays 0; req0 next beat uses stored carry.
//  5. resp_ready=0 for 4 cycles with a beat held
//     -> resp_* stable, both readies 0; ready returns the cycle resp_ready=1.
//  6. rst_n low mid-packet (after beat0)
//     -> resp_valid=0 immediately; after release, IDLE with pointer=req0, req1 can win.

Source files
------------

// File: rtl/rca_share_arbiter.sv
// Two requesters share one ripple-carry adder; multi-beat packets chain carry
// between beats, and one registered valid/ready stage carries results out.

module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module thirtytwobitRCA #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_bit
    rca_fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
  assign cout = c[W];
endmodule

module rca_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_last,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_last,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_sum,
  output logic        resp_cout,
  output logic        resp_id,
  output logic        resp_last,
  output logic [3:0]  resp_idx
);
  typedef enum logic {IDLE, LOCK} state_t;

  state_t      state, state_nxt;
  logic        owner, rr_ptr, carry_q;
  logic [3:0]  idx_q;
  logic        out_free, sel, sel_valid, sel_last, accept;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  assign out_free = !resp_valid || resp_ready;

  always_comb begin
    state_nxt = state;
    sel       = 1'b0;
    if (state == LOCK)
      sel = owner;
    else if (req0_valid && req1_valid)
      sel = RR_EN ? rr_ptr : 1'b0;
    else
      sel = req1_valid && !req0_valid;
    sel_valid  = sel ? req1_valid : req0_valid;
    sel_last   = sel ? req1_last  : req0_last;
    accept     = sel_valid && out_free;
    // Locked owner keeps the port even while it stalls its valid.
    req0_ready = out_free && !sel;
    req1_ready = out_free && sel;
    if (accept) state_nxt = sel_last ? IDLE : LOCK;
  end

  assign add_a   = sel ? req1_a : req0_a;
  assign add_b   = sel ? req1_b : req0_b;
  assign add_cin = (state == LOCK) ? carry_q : (sel ? req1_cin : req0_cin);

  thirtytwobitRCA #(.W(32)) u_rca (
    .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      carry_q    <= 1'b0;
      idx_q      <= 4'd0;
      resp_valid <= 1'b0;
      resp_sum   <= 32'd0;
      resp_cout  <= 1'b0;
      resp_id    <= 1'b0;
      resp_last  <= 1'b0;
      resp_idx   <= 4'd0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_sum   <= add_sum;
      resp_cout  <= add_cout;
      resp_id    <= sel;
      resp_last  <= sel_last;
      resp_idx   <= idx_q;
      if (sel_last) begin
        carry_q <= 1'b0;
        idx_q   <= 4'd0;
        if (RR_EN) rr_ptr <= !sel;
      end else begin
        owner   <= sel;
        carry_q <= add_cout;
        if (idx_q != 4'hF) idx_q <= idx_q + 4'd1;
      end
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rca_share_arbiter.sv
// Bench: DUT 0 is round-robin, DUT 1 fixed priority; a packet-level model
// predicts readies and responses for both, checked every cycle.

module tb_rca_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] v0 = '0, v1 = '0, c0 = '0, c1 = '0, l0 = '0, l1 = '0, rr = 2'b11;
  logic [1:0][31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] o_r0, o_r1, o_rv, o_co, o_id, o_last;
  logic [1:0][31:0] o_sum;
  logic [1:0][3:0]  o_idx;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  rca_share_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_ready(o_r0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req0_cin(c0[0]), .req0_last(l0[0]),
    .req1_valid(v1[0]), .req1_ready(o_r1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .req1_cin(c1[0]), .req1_last(l1[0]),
    .resp_valid(o_rv[0]), .resp_ready(rr[0]), .resp_sum(o_sum[0]), .resp_cout(o_co[0]),
    .resp_id(o_id[0]), .resp_last(o_last[0]), .resp_idx(o_idx[0]));

  rca_share_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_ready(o_r0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req0_cin(c0[1]), .req0_last(l0[1]),
    .req1_valid(v1[1]), .req1_ready(o_r1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .req1_cin(c1[1]), .req1_last(l1[1]),
    .resp_valid(o_rv[1]), .resp_ready(rr[1]), .resp_sum(o_sum[1]), .resp_cout(o_co[1]),
    .resp_id(o_id[1]), .resp_last(o_last[1]), .resp_idx(o_idx[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the adder (-1 = nobody), running carry and beat count per
  // packet, the round-robin turn, and the response currently presented.
  int          m_owner[2] = '{-1, -1};
  bit          m_carry[2] = '{0, 0};
  int          m_beat[2]  = '{0, 0};
  bit          m_turn[2]  = '{0, 0};
  bit          m_rv[2]    = '{0, 0};
  logic [31:0] m_sum[2]   = '{0, 0};
  bit          m_co[2]    = '{0, 0};
  bit          m_id[2]    = '{0, 0};
  bit          m_last[2]  = '{0, 0};
  int          m_idx[2]   = '{0, 0};

  function automatic int grant(input int k);
    if (m_owner[k] >= 0) return m_owner[k];
    if (v0[k] && v1[k]) return (k == 0) ? int'(m_turn[k]) : 0;
    if (v1[k]) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = -1; m_carry[k] = 0; m_beat[k] = 0; m_turn[k] = 0;
        m_rv[k] = 0; m_sum[k] = 0; m_co[k] = 0; m_id[k] = 0; m_last[k] = 0; m_idx[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int g;
        bit vg, lg, cg, free;
        logic [32:0] tot;
        g    = grant(k);
        free = !m_rv[k] || rr[k];
        vg   = g ? v1[k] : v0[k];
        lg   = g ? l1[k] : l0[k];
        cg   = (m_owner[k] >= 0) ? m_carry[k] : (g ? c1[k] : c0[k]);
        if (free && vg) begin
          tot = 33'(g ? a1[k] : a0[k]) + 33'(g ? b1[k] : b0[k]) + 33'(cg);
          m_rv[k] = 1; m_sum[k] = tot[31:0]; m_co[k] = tot[32]; m_id[k] = g[0];
          m_last[k] = lg; m_idx[k] = (m_beat[k] > 15) ? 15 : m_beat[k];
          if (lg) begin
            m_owner[k] = -1; m_carry[k] = 0; m_beat[k] = 0;
            if (k == 0) m_turn[k] = !g[0];
          end else begin
            m_owner[k] = g; m_carry[k] = tot[32]; m_beat[k]++;
          end
        end else if (rr[k]) m_rv[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit free;
      int g;
      free = !m_rv[k] || rr[k];
      g = grant(k);
      chk($sformatf("ready0[%0d]", k), 32'(o_r0[k]), 32'(free && g == 0));
      chk($sformatf("ready1[%0d]", k), 32'(o_r1[k]), 32'(free && g == 1));
      chk($sformatf("resp_valid[%0d]", k), 32'(o_rv[k]), 32'(m_rv[k]));
      if (m_rv[k]) begin
        chk($sformatf("resp_sum[%0d]", k), o_sum[k], m_sum[k]);
        chk($sformatf("resp_meta[%0d]", k), {24'd0, o_co[k], o_id[k], o_last[k], 1'b0, o_idx[k]},
            {24'd0, m_co[k], m_id[k], m_last[k], 1'b0, 4'(m_idx[k])});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until the DUT takes it; ends 1 after the accepting edge.
  task automatic send(input int k, input bit s, input logic [31:0] a, input logic [31:0] b,
                      input bit c, input bit l);
    bit ok = 0;
    if (!s) begin v0[k] = 1; a0[k] = a; b0[k] = b; c0[k] = c; l0[k] = l; end
    else    begin v1[k] = 1; a1[k] = a; b1[k] = b; c1[k] = c; l1[k] = l; end
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (s ? o_r1[k] : o_r0[k]) ok = 1;
      tick();
    end
    chk("send_accept", 32'(ok), 32'd1);
    if (!s) v0[k] = 0; else v1[k] = 0;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(o_rv[0]), 32'd0);
    chk("rst_sum", o_sum[0], 32'd0);
    chk("rst_meta", {o_co[0], o_id[0], o_last[0], o_idx[0]}, 32'd0);
    tick(); rst_n = 1; tick();

    // single beat wrapping to zero
    send(0, 0, 32'hFFFF_FFFF, 32'd1, 0, 1);
    chk("t1_sum", o_sum[0], 32'd0);
    chk("t1_meta", {o_rv[0], o_co[0], o_id[0], o_last[0], o_idx[0]}, {1'b1, 1'b1, 1'b0, 1'b1, 4'd0});

    // 64-bit add: carry ripples into the second beat
    send(0, 0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    send(0, 0, 32'd0, 32'd0, 0, 1);
    chk("t2_sum", o_sum[0], 32'd1);
    chk("t2_meta", {o_co[0], o_last[0], o_idx[0]}, {1'b0, 1'b1, 4'd1});

    // alternate under round robin (req1 first to hand the turn back to req0)
    send(0, 1, 32'd3, 32'd4, 0, 1);
    v0[0] = 1; v1[0] = 1; l0[0] = 1; l1[0] = 1; a0[0] = 10; a1[0] = 20;
    v0[1] = 1; v1[1] = 1; l0[1] = 1; l1[1] = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_rr_id", 32'(o_id[0]), 32'(i % 2));
      chk("t3_fp_id", 32'(o_id[1]), 32'd0);
    end
    v0 = '0; v1 = '0; tick();

    // owner stalls mid-packet; req1 is held off, carry survives the gap
    send(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    chk("t4_b0", {o_co[0], o_sum[0][30:0]}, {1'b1, 31'h7FFF_FFFF});
    v1[0] = 1; l1[0] = 1;
    for (int i = 0; i < 3; i++) begin chk("t4_r1_held", 32'(o_r1[0]), 32'd0); tick(); end
    v1[0] = 0;
    send(0, 0, 32'd1, 32'd2, 0, 1);
    chk("t4_sum", o_sum[0], 32'd4);
    tick();

    // consumer backpressure
    rr[0] = 0;
    send(0, 0, 32'd5, 32'd6, 0, 1);
    v0[0] = 1; a0[0] = 7; b0[0] = 8; v1[0] = 1; l1[0] = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_sum", o_sum[0], 32'd11);
      chk("t5_readies", {o_r0[0], o_r1[0]}, 32'd0);
      tick();
    end
    rr[0] = 1; #1;
    chk("t5_ready_back", {o_r0[0], o_r1[0]}, 32'b01);
    tick(); v1[0] = 0; tick(); v0[0] = 0; tick();

    // beat index saturates at 15
    for (int i = 0; i < 17; i++) send(0, 0, 32'(i), 32'd0, 0, i == 16);
    chk("idx_sat", 32'(o_idx[0]), 32'd15);
    tick();

    // reset mid-packet
    send(0, 0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    rst_n = 0; #1;
    chk("t6_valid", 32'(o_rv[0]), 32'd0);
    chk("t6_sum", o_sum[0], 32'd0);
    tick(); rst_n = 1;
    v0[0] = 1; v1[0] = 1; l0[0] = 1; l1[0] = 1; #1;
    chk("t6_ptr_req0", {o_r0[0], o_r1[0]}, 32'b10);
    v0[0] = 0; #1;
    chk("t6_req1_wins", {o_r0[0], o_r1[0]}, 32'b01);
    tick(); v1[0] = 0; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
